reg_scan_port: RTL and testbench

Debug/host access engine sitting on the far side of the `reg_file` read/write ports. It accepts a single command, then either streams a contiguous window of registers out over a valid/ready port (DUMP) or writes a window of registers from a valid/ready input stream (LOAD). It owns the `reg_file` ports while busy, so test hosts and the boot loader can inspect or preload the 16×8 register file without core involvement.

---
 rtl/rf_pkg.sv | 18 +
 rtl/out_stage.sv | 46 ++++
 rtl/reg_scan_port.sv | 158 +++++++++++++++
 tb/tb_reg_scan_port.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared register-file definitions: geometry, scan-port op codes and FSM states.
package rf_pkg;

  localparam int unsigned RF_ADDR_W = 4;
  localparam int unsigned RF_DATA_W = 8;
  localparam int unsigned RF_DEPTH  = 1 << RF_ADDR_W;

  localparam logic OP_DUMP = 1'b0;
  localparam logic OP_LOAD = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DUMP = 2'd1,
    ST_LOAD = 2'd2,
    ST_FIN  = 2'd3
  } scan_state_e;

endpackage

// File: rtl/out_stage.sv
// Single-entry valid/ready output register for DUMP beats.
module out_stage
  import rf_pkg::*;
#(
  parameter int unsigned ADDR_W = RF_ADDR_W,
  parameter int unsigned DATA_W = RF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_valid_i,
  input  logic [ADDR_W-1:0] push_addr_i,
  input  logic [DATA_W-1:0] push_data_i,
  output logic              push_ready_c,
  input  logic              out_ready_i,
  output logic              out_valid_o,
  output logic [ADDR_W-1:0] out_addr_o,
  output logic [DATA_W-1:0] out_data_o
);

  logic              valid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  // Slot may be refilled when empty or when its current beat is leaving.
  assign push_ready_c = !valid_q || out_ready_i;

  // Payload is only written on a push, so it holds steady through stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else if (push_ready_c) begin
      valid_q <= push_valid_i;
      if (push_valid_i) begin
        addr_q <= push_addr_i;
        data_q <= push_data_i;
      end
    end
  end

  assign out_valid_o = valid_q;
  assign out_addr_o  = addr_q;
  assign out_data_o  = data_q;

endmodule

// File: rtl/reg_scan_port.sv
// Host-side DUMP/LOAD engine that owns the reg_file ports while a command runs.
module reg_scan_port
  import rf_pkg::*;
#(
  parameter int unsigned ADDR_W = RF_ADDR_W,
  parameter int unsigned DATA_W = RF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [ADDR_W:0]   cmd_count,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rf_ra,
  output logic [ADDR_W-1:0] rf_rb,
  input  logic [DATA_W-1:0] rf_read_a,
  output logic [ADDR_W-1:0] rf_wa,
  output logic [DATA_W-1:0] rf_wd,
  output logic              rf_we
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  scan_state_e       state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [CNT_W-1:0]  remain_q;
  logic              cmd_ready_q;
  logic              busy_q;
  logic              in_ready_q;
  logic              done_q;
  logic              rf_we_q;
  logic [ADDR_W-1:0] rf_wa_q;
  logic [DATA_W-1:0] rf_wd_q;

  logic              remain_zero_c;
  logic              dump_push_c;
  logic              push_ready_c;
  logic              dump_fire_c;
  logic              load_fire_c;
  logic [CNT_W-1:0]  remain_dec_c;
  logic [CNT_W-1:0]  count_sat_c;

  // Handshake qualifiers and counter arithmetic.
  assign remain_zero_c = (remain_q == '0);
  assign dump_push_c   = (state_q == ST_DUMP) && !remain_zero_c;
  assign dump_fire_c   = dump_push_c && push_ready_c;
  assign load_fire_c   = (state_q == ST_LOAD) && in_valid && in_ready_q;
  assign remain_dec_c  = remain_q - CNT_W'(1);
  assign count_sat_c   = (cmd_count > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : cmd_count;

  // Command FSM, window counters and the registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      remain_q    <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      done_q      <= 1'b0;
      rf_we_q     <= 1'b0;
      rf_wa_q     <= '0;
      rf_wd_q     <= '0;
    end else begin
      rf_we_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            ptr_q       <= cmd_base;
            remain_q    <= count_sat_c;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (count_sat_c == '0) begin
              state_q <= ST_FIN;
            end else if (cmd_op == OP_LOAD) begin
              state_q <= ST_LOAD;
            end else begin
              state_q <= ST_DUMP;
            end
          end
        end
        ST_DUMP: begin
          if (dump_fire_c) begin
            ptr_q    <= ptr_q + ADDR_W'(1);
            remain_q <= remain_dec_c;
          end else if (remain_zero_c && push_ready_c) begin
            // Window exhausted and the final beat has left the output slot.
            state_q <= ST_FIN;
          end
        end
        ST_LOAD: begin
          if (load_fire_c) begin
            rf_we_q    <= 1'b1;
            rf_wa_q    <= ptr_q;
            rf_wd_q    <= in_data;
            ptr_q      <= ptr_q + ADDR_W'(1);
            remain_q   <= remain_dec_c;
            in_ready_q <= (remain_dec_c != '0);
            if (remain_dec_c == '0) begin
              state_q <= ST_FIN;
            end
          end else begin
            in_ready_q <= !remain_zero_c;
          end
        end
        ST_FIN: begin
          done_q      <= 1'b1;
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // DUMP beats are captured straight from the combinational read port.
  out_stage #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_out_stage (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_valid_i (dump_push_c),
    .push_addr_i  (ptr_q),
    .push_data_i  (rf_read_a),
    .push_ready_c (push_ready_c),
    .out_ready_i  (out_ready),
    .out_valid_o  (out_valid),
    .out_addr_o   (out_addr),
    .out_data_o   (out_data)
  );

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign in_ready  = in_ready_q;
  assign done      = done_q;
  assign rf_ra     = ptr_q;
  assign rf_rb     = ptr_q;
  assign rf_we     = rf_we_q;
  assign rf_wa     = rf_wa_q;
  assign rf_wd     = rf_wd_q;

endmodule

// File: tb/tb_reg_scan_port.sv
// Scoreboard bench for reg_scan_port with a behavioural 16x8 register file.
module tb_reg_scan_port;
  import rf_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid, cmd_ready, cmd_op;
  logic [3:0] cmd_base;
  logic [4:0] cmd_count;
  logic       out_valid, out_ready;
  logic [3:0] out_addr;
  logic [7:0] out_data;
  logic       in_valid, in_ready;
  logic [7:0] in_data;
  logic       busy, done;
  logic [3:0] rf_ra, rf_rb, rf_wa;
  logic [7:0] rf_read_a, rf_wd;
  logic       rf_we;

  logic [7:0]  rf_mem [16];
  logic [7:0]  exp_mem [16];
  logic [11:0] beat_q [$];
  logic [11:0] wr_q [$];
  logic [7:0]  load_data [$];

  int pass_cnt = 0;
  int fail_cnt = 0;
  int cyc = 0;
  int done_seen = 0;
  int exp_done = 0;
  logic       stall_mode = 1'b0;
  logic [3:0] rdy_pat = 4'b1001;
  logic [1:0] rdy_idx = 2'd0;
  logic       prev_stall = 1'b0;
  logic [3:0] prev_addr;
  logic [7:0] prev_data;

  reg_scan_port dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_base(cmd_base), .cmd_count(cmd_count),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .busy(busy), .done(done),
    .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_read_a(rf_read_a),
    .rf_wa(rf_wa), .rf_wd(rf_wd), .rf_we(rf_we)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural reg_file: combinational read, write on the rising edge.
  assign rf_read_a = rf_mem[rf_ra];
  always @(posedge clk) if (rf_we) rf_mem[rf_wa] <= rf_wd;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    if (act == exp) pass_cnt++;
    else begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    fail_cnt++;
    $display("FAIL %s: got timeout/unexpected event, expected none", name);
  endtask

  // Beat and write monitors: pop expectations whenever the DUT presents something.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_addr_stable", 32'(out_addr), 32'(prev_addr));
        chk("stall_data_stable", 32'(out_data), 32'(prev_data));
      end
      prev_stall = out_valid && !out_ready;
      prev_addr  = out_addr;
      prev_data  = out_data;
      if (out_valid && out_ready) begin
        if (beat_q.size() == 0) fail_now("beat_unexpected");
        else chk("beat", 32'({out_addr, out_data}), 32'(beat_q.pop_front()));
      end
      if (rf_we) begin
        if (wr_q.size() == 0) fail_now("write_unexpected");
        else chk("write", 32'({rf_wa, rf_wd}), 32'(wr_q.pop_front()));
      end
      if (done) done_seen++;
    end
  end

  // out_ready driver: held high, or a repeating 1,0,0,1 pattern when stalling.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (stall_mode) begin
        out_ready = rdy_pat[rdy_idx];
        rdy_idx   = rdy_idx + 2'd1;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 1);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_out_addr"},  32'(out_addr),  0);
    chk({tag, "_out_data"},  32'(out_data),  0);
    chk({tag, "_in_ready"},  32'(in_ready),  0);
    chk({tag, "_busy"},      32'(busy),      0);
    chk({tag, "_done"},      32'(done),      0);
    chk({tag, "_rf_we"},     32'(rf_we),     0);
    chk({tag, "_rf_wa"},     32'(rf_wa),     0);
    chk({tag, "_rf_wd"},     32'(rf_wd),     0);
    chk({tag, "_rf_ra"},     32'(rf_ra),     0);
    chk({tag, "_rf_rb"},     32'(rf_rb),     0);
  endtask

  // Offer a command (caller is just after a rising edge); n = acceptance edge.
  task automatic send_cmd(input logic op, input logic [3:0] base, input logic [4:0] count,
                          output int n);
    bit acc = 1'b0;
    int guard = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_base = base; cmd_count = count;
    while (!acc && guard < 200) begin
      @(negedge clk); acc = cmd_ready;
      @(posedge clk); #1;
      guard++;
    end
    if (!acc) fail_now("cmd_accept_timeout");
    cmd_valid = 1'b0;
    n = cyc;
  endtask

  task automatic expect_dump(input logic [3:0] base, input int count);
    logic [3:0] a;
    for (int i = 0; i < count; i++) begin
      a = base + 4'(i);
      beat_q.push_back({a, exp_mem[a]});
    end
    exp_done++;
  endtask

  task automatic wait_done(output int c, output bit saw_valid);
    bit got = 1'b0;
    int guard = 0;
    saw_valid = 1'b0;
    while (!got && guard < 200) begin
      @(negedge clk);
      saw_valid = saw_valid | out_valid;
      got = done;
      guard++;
    end
    if (!got) fail_now("done_timeout");
    c = cyc;
    @(posedge clk); #1;
  endtask

  // LOAD using load_data; returns the acceptance edge.
  task automatic run_load(input logic [3:0] base, output int n);
    logic [3:0] a;
    bit hs;
    int guard;
    for (int i = 0; i < load_data.size(); i++) begin
      a = base + 4'(i);
      wr_q.push_back({a, load_data[i]});
      exp_mem[a] = load_data[i];
    end
    exp_done++;
    send_cmd(OP_LOAD, base, 5'(load_data.size()), n);
    for (int i = 0; i < load_data.size(); i++) begin
      in_valid = 1'b1; in_data = load_data[i];
      hs = 1'b0; guard = 0;
      while (!hs && guard < 50) begin
        @(negedge clk); hs = in_ready;
        @(posedge clk); #1;
        guard++;
      end
      if (!hs) fail_now("load_beat_timeout");
    end
    in_valid = 1'b0;
  endtask

  initial begin
    int n, n2, c;
    bit sv;
    bit hs;
    int guard;
    cmd_valid = 1'b0; cmd_op = 1'b0; cmd_base = '0; cmd_count = '0;
    in_valid = 1'b0; in_data = '0;
    repeat (2) @(posedge clk); #1;
    check_reset_outputs("por");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Preload all 16 registers with i*0x11.
    load_data.delete();
    for (int i = 0; i < 16; i++) load_data.push_back(8'(i * 17));
    run_load(4'd0, n);
    wait_done(c, sv);
    chk("preload_done_cycle", 32'(c), 32'(n + 18));
    chk("preload_we_idle", 32'(rf_we), 0);
    for (int i = 0; i < 16; i++) chk("preload_mem", 32'(rf_mem[i]), 32'(i * 17));

    // Full-window dump with continuous ready.
    expect_dump(4'd0, 16);
    send_cmd(OP_DUMP, 4'd0, 5'd16, n);
    wait_done(c, sv);
    chk("dump16_done_cycle", 32'(c), 32'(n + 18));

    // Wrapping dump under a 1,0,0,1 ready pattern.
    stall_mode = 1'b1;
    expect_dump(4'd14, 4);
    send_cmd(OP_DUMP, 4'd14, 5'd4, n);
    wait_done(c, sv);
    stall_mode = 1'b0;
    @(posedge clk); #1;

    // Single-register load then read back; neighbour untouched.
    load_data.delete();
    load_data.push_back(8'hAA);
    run_load(4'd3, n);
    wait_done(c, sv);
    chk("load1_done_cycle", 32'(c), 32'(n + 3));
    expect_dump(4'd3, 1);
    send_cmd(OP_DUMP, 4'd3, 5'd1, n);
    wait_done(c, sv);
    chk("reg5_unchanged", 32'(rf_mem[5]), 32'h55);

    // Zero-count dump: no beats, done one edge after acceptance.
    expect_dump(4'd6, 0);
    send_cmd(OP_DUMP, 4'd6, 5'd0, n);
    wait_done(c, sv);
    chk("cnt0_done_cycle", 32'(c), 32'(n + 1));
    chk("cnt0_no_valid", 32'(sv), 0);

    // Command held while busy is taken only once back in IDLE.
    expect_dump(4'd8, 4);
    send_cmd(OP_DUMP, 4'd8, 5'd4, n);
    expect_dump(4'd0, 0);
    send_cmd(OP_DUMP, 4'd0, 5'd0, n2);
    chk("held_cmd_accept_edge", 32'(n2), 32'(n + 7));
    wait_done(c, sv);
    chk("held_cmd_done_cycle", 32'(c), 32'(n2 + 1));

    // Oversized count saturates to a full 16-register window.
    expect_dump(4'd2, 16);
    send_cmd(OP_DUMP, 4'd2, 5'd20, n);
    wait_done(c, sv);
    chk("sat_done_cycle", 32'(c), 32'(n + 18));

    // Reset after a LOAD handshake but before its write lands.
    send_cmd(OP_LOAD, 4'd7, 5'd2, n);
    in_valid = 1'b1; in_data = 8'h3C;
    hs = 1'b0; guard = 0;
    while (!hs && guard < 50) begin
      @(negedge clk); hs = in_ready;
      @(posedge clk); #1;
      guard++;
    end
    if (!hs) fail_now("abort_handshake_timeout");
    #1 rst_n = 1'b0;
    #1;
    in_valid = 1'b0;
    check_reset_outputs("abort");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("abort_reg7_unchanged", 32'(rf_mem[7]), 32'(exp_mem[7]));

    chk("beats_outstanding", 32'(beat_q.size()), 0);
    chk("writes_outstanding", 32'(wr_q.size()), 0);
    chk("done_count", 32'(done_seen), 32'(exp_done));

    $display("%0d/%0d checks passed", pass_cnt, pass_cnt + fail_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
